// File: rtl/ahb_sram_slave.sv
// AHB-lite SRAM responder with byte lanes, two-cycle ERROR and write-to-read forwarding.
// Optional data-phase wait states are built only when AHB_SLV_WAIT_EN is defined.
module ahb_sram_slave #(
   parameter int ADDR_WIDTH  = 12,
   parameter int MEM_WORDS   = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic        HMASTLOCK,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   localparam int IW = ADDR_WIDTH - 2;
   localparam int MW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ERR1 = 2'd2;
   localparam logic [1:0] ST_ERR2 = 2'd3;

   logic [1:0]    state;
   logic [1:0]    nextState;
   logic [31:0]   mem [0:MEM_WORDS-1];

   logic          dpValid;
   logic          dpWrite;
   logic [MW-1:0] dpIndex;
   logic [3:0]    dpStrb;
   logic [31:0]   rdataReg;

   logic [IW-1:0] addrIndex;
   logic          accept;
   logic          addrError;
   logic          acceptOk;
   logic          acceptErr;
   logic          commitWrite;
   logic [31:0]   fwdWord;
   logic          unusedInputs;

`ifdef AHB_SLV_WAIT_EN
   logic [3:0]    waitCnt;
`endif

   function automatic logic [3:0] byteStrobe(input logic [2:0] size, input logic [1:0] offset);
      logic [3:0] strb;
      case (size)
         3'd0:    strb = 4'b0001 << offset;
         3'd1:    strb = offset[1] ? 4'b1100 : 4'b0011;
         default: strb = 4'b1111;
      endcase
      return strb;
   endfunction

   assign unusedInputs = ^{HADDR[31:ADDR_WIDTH], HTRANS[0], HBURST, HPROT, HMASTLOCK, 4'(WAIT_STATES)};

   assign addrIndex = HADDR[ADDR_WIDTH-1:2];
   assign accept    = HSEL & HREADY & HTRANS[1] & ((state == ST_IDLE) | (state == ST_ERR2));
   assign addrError = (32'(addrIndex) >= MEM_WORDS) |
                      (HSIZE > 3'd2) |
                      ((HSIZE == 3'd1) & HADDR[0]) |
                      ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
   assign acceptOk  = accept & ~addrError;
   assign acceptErr = accept & addrError;

   // A pending write's data phase ends whenever we sit in IDLE with HREADYOUT high
   assign commitWrite = (state == ST_IDLE) & dpValid & dpWrite;

   // Read word for a newly accepted read, with lanes of a completing write to the same word merged in
   always_comb begin
      fwdWord = mem[addrIndex[MW-1:0]];
      if (commitWrite && (dpIndex == addrIndex[MW-1:0])) begin
         for (int b = 0; b < 4; b++) begin
            if (dpStrb[b]) fwdWord[8*b +: 8] = HWDATA[8*b +: 8];
         end
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         ST_IDLE, ST_ERR2: begin
            if (acceptErr) begin
               nextState = ST_ERR1;
            end else begin
               nextState = ST_IDLE;
`ifdef AHB_SLV_WAIT_EN
               if (acceptOk && (WAIT_STATES > 0)) nextState = ST_WAIT;
`endif
            end
         end
         ST_ERR1: nextState = ST_ERR2;
`ifdef AHB_SLV_WAIT_EN
         ST_WAIT: if (waitCnt == 4'd0) nextState = ST_IDLE;
`endif
         default: nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state    <= ST_IDLE;
         dpValid  <= 1'b0;
         rdataReg <= 32'd0;
      end else begin
         state <= nextState;
         if (acceptOk) dpValid <= 1'b1;
         else if (state == ST_IDLE) dpValid <= 1'b0;
         // Read data is held for the whole data phase, including any wait cycles
         if (acceptOk && !HWRITE) rdataReg <= fwdWord;
         else if (state == ST_WAIT) rdataReg <= rdataReg;
         else rdataReg <= 32'd0;
      end
   end

   always_ff @(posedge HCLK) begin
      if (acceptOk) begin
         dpWrite <= HWRITE;
         dpIndex <= addrIndex[MW-1:0];
         dpStrb  <= byteStrobe(HSIZE, HADDR[1:0]);
      end
   end

`ifdef AHB_SLV_WAIT_EN
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         waitCnt <= 4'd0;
      end else if (acceptOk) begin
         waitCnt <= 4'(WAIT_STATES - 1);
      end else if ((state == ST_WAIT) && (waitCnt != 4'd0)) begin
         waitCnt <= waitCnt - 4'd1;
      end
   end
`endif

   // Reset on the completing edge drops the pending write
   always_ff @(posedge HCLK) begin
      if (HRESETn && commitWrite) begin
         for (int b = 0; b < 4; b++) begin
            if (dpStrb[b]) mem[dpIndex][8*b +: 8] <= HWDATA[8*b +: 8];
         end
      end
   end

   assign HREADYOUT = (state == ST_IDLE) | (state == ST_ERR2);
   assign HRESP     = (state == ST_ERR1) | (state == ST_ERR2);
   assign HRDATA    = rdataReg;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomised bench for ahb_sram_slave against a sequentially-consistent memory model.
// Honours AHB_SLV_WAIT_EN: the DUT gets WAIT_STATES=3, expected waits follow the macro.
module tb_ahb_sram_slave;

   localparam int AW    = 13;
   localparam int WORDS = 1024;
`ifdef AHB_SLV_WAIT_EN
   localparam int EXP_WAIT = 3;
`else
   localparam int EXP_WAIT = 0;
`endif

   localparam int K_NONE = 0;
   localparam int K_RD   = 1;
   localparam int K_WR   = 2;
   localparam int K_ERR  = 3;

   typedef struct {
      bit        sel;
      bit [1:0]  trans;
      bit        write;
      bit [31:0] addr;
      bit [2:0]  size;
      bit [31:0] wdata;
   } xferT;

   logic        HCLK;
   logic        HRESETn;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;

   int checkCount = 0;
   int passCount  = 0;

   bit [31:0] modelMem [int];
   int        prevKind  = K_NONE;
   bit [31:0] prevAddr  = 0;
   bit [2:0]  prevSize  = 0;
   bit [31:0] prevWdata = 0;
   bit [31:0] prevData  = 0;

   ahb_sram_slave #(.ADDR_WIDTH(AW), .MEM_WORDS(WORDS), .WAIT_STATES(3)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
      .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
   );

   // Single slave on the bus, so the muxed ready is our own
   assign HREADY = HREADYOUT;

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
   endtask

   function automatic int wordIndex(input bit [31:0] addr);
      return int'((addr >> 2) & ((32'd1 << (AW - 2)) - 1));
   endfunction

   function automatic bit isError(input bit [31:0] addr, input bit [2:0] size);
      if (wordIndex(addr) >= WORDS) return 1'b1;
      if (size > 2) return 1'b1;
      if ((addr % (32'd1 << size)) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit [31:0] modelRead(input bit [31:0] addr);
      int idx = wordIndex(addr);
      if (modelMem.exists(idx)) return modelMem[idx];
      return 32'd0;
   endfunction

   task automatic modelWrite(input bit [31:0] addr, input bit [2:0] size, input bit [31:0] wdata);
      int        idx   = wordIndex(addr);
      int        nb    = 1 << size;
      int        first = int'(addr % 4) / nb * nb;
      bit [31:0] word  = modelRead(addr);
      for (int b = first; b < first + nb; b++) word[8*b +: 8] = wdata[8*b +: 8];
      modelMem[idx] = word;
   endtask

   function automatic xferT mk(input bit sel, input bit [1:0] trans, input bit write,
                               input bit [31:0] addr, input bit [2:0] size, input bit [31:0] wdata);
      xferT t;
      t.sel = sel; t.trans = trans; t.write = write; t.addr = addr; t.size = size; t.wdata = wdata;
      return t;
   endfunction

   // Drives the address phase of t while checking the data phase of the previous transfer
   task automatic applyStimulus(input xferT t);
      int low  = 0;
      bit done = 0;
      bit rdy;
      HSEL      = t.sel;
      HTRANS    = t.trans;
      HADDR     = t.addr;
      HWRITE    = t.write;
      HSIZE     = t.size;
      HBURST    = 3'($urandom);
      HPROT     = 4'($urandom);
      HMASTLOCK = 1'($urandom);
      HWDATA    = prevWdata;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge HCLK);
         rdy = HREADYOUT;
         if (!rdy) low++;
         checkOutput("hrdata", HRDATA, (prevKind == K_RD) ? prevData : 32'd0);
         checkOutput("hresp", 32'(HRESP), (prevKind == K_ERR) ? 32'd1 : 32'd0);
         if (rdy) begin
            checkOutput("waitCycles", 32'(low),
                        (prevKind == K_ERR) ? 32'd1 : (prevKind == K_NONE) ? 32'd0 : 32'(EXP_WAIT));
            done = 1;
         end
         @(posedge HCLK);
         #1;
      end
      if (!done) checkOutput("readyTimeout", 32'd0, 32'd1);
      if (prevKind == K_WR) modelWrite(prevAddr, prevSize, prevWdata);
      if (!(t.sel && t.trans[1])) prevKind = K_NONE;
      else if (isError(t.addr, t.size)) prevKind = K_ERR;
      else if (t.write) prevKind = K_WR;
      else prevKind = K_RD;
      prevAddr  = t.addr;
      prevSize  = t.size;
      prevWdata = t.wdata;
      prevData  = (prevKind == K_RD) ? modelRead(t.addr) : 32'd0;
   endtask

   task automatic resetMidWrite(input bit [31:0] addr, input bit [31:0] data);
      applyStimulus(mk(1, 2'd2, 1, addr, 3'd2, data));
      HWDATA  = data;
      HSEL    = 1'b0;
      HTRANS  = 2'd0;
      HRESETn = 1'b0;
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      @(negedge HCLK);
      checkOutput("rstReady", 32'(HREADYOUT), 32'd1);
      checkOutput("rstResp", 32'(HRESP), 32'd0);
      checkOutput("rstRdata", HRDATA, 32'd0);
      prevKind = K_NONE;
      @(posedge HCLK);
      #1;
   endtask

   function automatic xferT randomXfer();
      xferT t;
      int   idx;
      int   r;
      bit [1:0] off;
      t.sel   = ($urandom_range(0, 9) != 0);
      t.trans = ($urandom_range(0, 3) != 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      t.write = 1'($urandom);
      r       = $urandom_range(0, 19);
      idx     = (r < 16) ? r : WORDS + $urandom_range(0, WORDS - 1);
      r       = $urandom_range(0, 9);
      t.size  = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
      off     = 2'($urandom);
      if ($urandom_range(0, 3) != 0) begin
         if (t.size == 3'd1) off[0] = 1'b0;
         if (t.size == 3'd2) off = 2'b00;
      end
      t.addr  = ($urandom & 32'hFFFF_E000) | (32'(idx) << 2) | 32'(off);
      t.wdata = $urandom;
      return t;
   endfunction

   initial begin
      HRESETn = 1'b0;
      HSEL = 0; HTRANS = 0; HADDR = 0; HWRITE = 0; HSIZE = 0;
      HBURST = 0; HPROT = 0; HMASTLOCK = 0; HWDATA = 0;
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      checkOutput("resetReady", 32'(HREADYOUT), 32'd1);
      checkOutput("resetResp", 32'(HRESP), 32'd0);
      checkOutput("resetRdata", HRDATA, 32'd0);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;

      for (int i = 0; i < 16; i++) applyStimulus(mk(1, 2'd2, 1, 32'(i * 4), 3'd2, $urandom));

      applyStimulus(mk(1, 2'd2, 1, 32'h10, 3'd2, 32'hDEADBEEF));
      applyStimulus(mk(1, 2'd2, 0, 32'h10, 3'd2, 32'h0));
      applyStimulus(mk(1, 2'd2, 1, 32'h10, 3'd2, 32'h11223344));
      applyStimulus(mk(1, 2'd2, 1, 32'h13, 3'd0, 32'hA500_0000));
      applyStimulus(mk(1, 2'd2, 0, 32'h10, 3'd2, 32'h0));
      applyStimulus(mk(1, 2'd2, 1, 32'h10, 3'd1, 32'h0000_5A5A));
      applyStimulus(mk(1, 2'd2, 0, 32'h10, 3'd2, 32'h0));
      applyStimulus(mk(1, 2'd2, 1, 32'h20, 3'd2, 32'h12345678));
      applyStimulus(mk(1, 2'd2, 0, 32'h20, 3'd2, 32'h0));
      applyStimulus(mk(1, 2'd2, 0, 32'h1000, 3'd2, 32'h0));
      applyStimulus(mk(1, 2'd2, 1, 32'h1000, 3'd2, 32'hFFFF_FFFF));
      applyStimulus(mk(1, 2'd2, 0, 32'h02, 3'd2, 32'h0));
      applyStimulus(mk(1, 2'd2, 1, 32'h11, 3'd1, 32'hFFFF_FFFF));
      applyStimulus(mk(1, 2'd2, 0, 32'h10, 3'd2, 32'h0));
      applyStimulus(mk(1, 2'd0, 1, 32'h10, 3'd2, 32'h0BAD_0BAD));
      applyStimulus(mk(1, 2'd1, 1, 32'h10, 3'd2, 32'h0BAD_0BAD));
      applyStimulus(mk(0, 2'd2, 1, 32'h10, 3'd2, 32'h0BAD_0BAD));
      applyStimulus(mk(1, 2'd2, 0, 32'h10, 3'd2, 32'h0));
      applyStimulus(mk(1, 2'd2, 0, 32'h00, 3'd2, 32'h0));

      for (int i = 0; i < 300; i++) applyStimulus(randomXfer());

      resetMidWrite(32'h24, 32'hCAFE_F00D);
      applyStimulus(mk(1, 2'd2, 0, 32'h24, 3'd2, 32'h0));
      applyStimulus(mk(1, 2'd0, 0, 32'h0, 3'd2, 32'h0));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
